sha256_round_engine: RTL and testbench

Parametrised single-block SHA-256 compression engine with internal K-constant ROM, internal chaining-value register and a streaming message-word input. It sits between the message block buffer and the hash-result consumer in the hashing datapath. It replaces command-bus sequencing with a START/BUSY/RES_VALID handshake. It adds selectable unrolling, chaining-source modes (IV, chained, externally loaded midstate) and flow-controlled message input.

---
 rtl/sha256_round_engine.sv | 190 +++++++++++++++++++
 tb/tb_sha256_round_engine.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: single-block SHA-256 compression with internal K ROM,
// persistent chaining register, streaming 16-word message load and
// UNROLL rounds per clock.
module sha256_round_engine #(
    parameter int UNROLL = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [1:0]   mode_i,
    input  logic [255:0] h_in_i,
    input  logic [31:0]  m_data_i,
    input  logic         m_valid_i,
    output logic         m_ready_o,
    output logic         busy_o,
    output logic [255:0] res_o,
    output logic         res_valid_o
);

    generate
        if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
            $error("sha256_round_engine: UNROLL must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_LOAD, S_ROUNDS, S_FINAL} state_e;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [6:0]     t_q, t_d;
    logic [31:0]    v_q [8], v_d [8];      // working variables a..h
    logic [31:0]    h_q [8], h_d [8];      // chaining value
    logic [31:0]    w_q [16], w_d [16];    // schedule window W_t..W_t+15
    logic [255:0]   res_q, res_d;
    logic           res_vld_q, res_vld_d;

    logic [31:0]    vs [UNROLL+1][8];
    logic [31:0]    ws [UNROLL+1][16];
    logic [31:0]    t1 [UNROLL];
    logic [31:0]    t2 [UNROLL];

    // UNROLL round steps chained combinationally, each also sliding the schedule window
    always_comb begin
        vs[0] = v_q;
        ws[0] = w_q;
        for (int i = 0; i < UNROLL; i++) begin
            t1[i] = vs[i][7] + bsig1(vs[i][4]) + ((vs[i][4] & vs[i][5]) ^ (~vs[i][4] & vs[i][6]))
                  + K[t_q[5:0] + 6'(i)] + ws[i][0];
            t2[i] = bsig0(vs[i][0]) + ((vs[i][0] & vs[i][1]) ^ (vs[i][0] & vs[i][2]) ^ (vs[i][1] & vs[i][2]));
            vs[i+1][0] = t1[i] + t2[i];
            vs[i+1][1] = vs[i][0];
            vs[i+1][2] = vs[i][1];
            vs[i+1][3] = vs[i][2];
            vs[i+1][4] = vs[i][3] + t1[i];
            vs[i+1][5] = vs[i][4];
            vs[i+1][6] = vs[i][5];
            vs[i+1][7] = vs[i][6];
            for (int j = 0; j < 15; j++) ws[i+1][j] = ws[i][j+1];
            ws[i+1][15] = ssig1(ws[i][14]) + ws[i][9] + ssig0(ws[i][1]) + ws[i][0];
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        m_ready_o = 1'b0;
        busy_o    = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_d = S_INIT;
            end
            S_INIT:   state_d = S_LOAD;
            S_LOAD: begin
                m_ready_o = 1'b1;
                if (m_valid_i && cnt_q == 4'd15) state_d = S_ROUNDS;
            end
            S_ROUNDS: if (t_q == 7'(64 - UNROLL)) state_d = S_FINAL;
            S_FINAL:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: H select, word capture, round update, final add
    always_comb begin
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        t_d       = t_q;
        v_d       = v_q;
        h_d       = h_q;
        w_d       = w_q;
        res_d     = res_q;
        res_vld_d = 1'b0;
        case (state_q)
            S_IDLE: if (start_i) mode_d = mode_i;
            S_INIT: begin
                for (int j = 0; j < 8; j++) begin
                    case (mode_q)
                        2'd1:    h_d[j] = h_q[j];
                        2'd2:    h_d[j] = h_in_i[255-32*j -: 32];
                        default: h_d[j] = IV[255-32*j -: 32];
                    endcase
                    v_d[j] = h_d[j];
                end
                cnt_d = '0;
            end
            S_LOAD: begin
                t_d = '0;
                if (m_valid_i) begin
                    w_d[cnt_q] = m_data_i;
                    cnt_d      = cnt_q + 4'd1;
                end
            end
            S_ROUNDS: begin
                v_d = vs[UNROLL];
                w_d = ws[UNROLL];
                t_d = t_q + 7'(UNROLL);
            end
            S_FINAL: begin
                for (int j = 0; j < 8; j++) begin
                    h_d[j]                 = h_q[j] + v_q[j];
                    res_d[255-32*j -: 32]  = h_q[j] + v_q[j];
                end
                res_vld_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State registers; H comes out of reset holding the IV so chaining starts clean
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            cnt_q     <= '0;
            t_q       <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                v_q[j] <= '0;
                h_q[j] <= IV[255-32*j -: 32];
            end
            for (int j = 0; j < 16; j++) w_q[j] <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            t_q       <= t_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            v_q       <= v_d;
            h_q       <= h_d;
            w_q       <= w_d;
        end
    end

    assign res_o       = res_q;
    assign res_valid_o = res_vld_q;

endmodule

// File: tb/tb_sha256_round_engine.sv
// Bench for sha256_round_engine: four instances (UNROLL 1/2/4/8) share one
// stimulus stream; a block-level SHA-256 reference predicts every output.
module tb_sha256_round_engine;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG2    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam int UOF [4] = '{1, 2, 4, 8};
    localparam int LAT [4] = '{82, 50, 34, 26};

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = '0;
    logic [255:0] h_in = '0;
    logic [31:0]  m_data = '0;
    logic         m_valid = 1'b0;
    logic [3:0]   m_ready, busy, res_valid;
    logic [255:0] res [4];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_start = 0;
    int lat_extra = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_round_engine #(.UNROLL(1 << g)) u_dut (
            .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .mode_i(mode), .h_in_i(h_in),
            .m_data_i(m_data), .m_valid_i(m_valid), .m_ready_o(m_ready[g]), .busy_o(busy[g]),
            .res_o(res[g]), .res_valid_o(res_valid[g])
        );
    end

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression of one 512-bit block (W0 in the top word)
    function automatic logic [255:0] compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0] W [64];
        logic [31:0] hw [8];
        logic [31:0] a, b, c, d, e, f, g, h, x1, x2;
        for (int t = 0; t < 16; t++) W[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            W[t] = (ror(W[t-2], 17) ^ ror(W[t-2], 19) ^ (W[t-2] >> 10)) + W[t-7]
                 + (ror(W[t-15], 7) ^ ror(W[t-15], 18) ^ (W[t-15] >> 3)) + W[t-16];
        for (int j = 0; j < 8; j++) hw[j] = hv[255-32*j -: 32];
        a = hw[0]; b = hw[1]; c = hw[2]; d = hw[3]; e = hw[4]; f = hw[5]; g = hw[6]; h = hw[7];
        for (int t = 0; t < 64; t++) begin
            x1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + W[t];
            x2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + x1; d = c; c = b; b = a; a = x1 + x2;
        end
        return {hw[0] + a, hw[1] + b, hw[2] + c, hw[3] + d, hw[4] + e, hw[5] + f, hw[6] + g, hw[7] + h};
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // Reference model: phase per instance, H register, captured words, predicted outputs
    int           ph [4];
    int           mcnt [4];
    int           rem [4];
    logic [1:0]   mmode [4];
    logic [255:0] mh [4], hs [4], eres [4];
    logic [511:0] mblk [4];
    logic         erv [4];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                ph[k] = 0; mcnt[k] = 0; mh[k] = IV; eres[k] = '0; erv[k] = 1'b0;
            end else begin
                erv[k] = 1'b0;
                case (ph[k])
                    0: if (start) begin mmode[k] = mode; ph[k] = 1; end
                    1: begin
                        hs[k] = (mmode[k] == 2'd1) ? mh[k] : (mmode[k] == 2'd2) ? h_in : IV;
                        mh[k] = hs[k]; mcnt[k] = 0; ph[k] = 2;
                    end
                    2: if (m_valid) begin
                        mblk[k][511-32*mcnt[k] -: 32] = m_data;
                        mcnt[k]++;
                        if (mcnt[k] == 16) begin ph[k] = 3; rem[k] = 64 / UOF[k]; end
                    end
                    3: begin rem[k]--; if (rem[k] == 0) ph[k] = 4; end
                    default: begin
                        eres[k] = compress(hs[k], mblk[k]);
                        mh[k] = eres[k]; erv[k] = 1'b1; ph[k] = 0;
                    end
                endcase
            end
        end
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("busy[%0d]", k), 256'(busy[k]), 256'(ph[k] != 0));
            chk($sformatf("m_ready[%0d]", k), 256'(m_ready[k]), 256'(ph[k] == 2));
            chk($sformatf("res_valid[%0d]", k), 256'(res_valid[k]), 256'(erv[k]));
            chk($sformatf("res[%0d]", k), res[k], eres[k]);
            if (res_valid[k])
                chk($sformatf("latency[%0d]", k), 256'(cyc - t_start), 256'(LAT[k] + lat_extra));
        end
    end

    // Called on a negedge; START is raised immediately so it lands on the next edge
    task automatic run_block(input logic [1:0] md, input logic [255:0] hin, input logic [511:0] blk,
                             input int gap_at, input int gap_len);
        int i, guard, gl;
        logic rdy;
        start = 1'b1; mode = md; h_in = hin; m_valid = 1'b1; m_data = blk[511 -: 32];
        #1;
        t_start = cyc + 1;
        lat_extra = gap_len;
        @(negedge clk);
        start = 1'b0;
        i = 0; guard = 0; gl = 0;
        while (i < 16 && guard < 200) begin
            if (i == gap_at && gl < gap_len) begin
                m_valid = 1'b0; start = 1'b1; mode = 2'd1; h_in = ~hin;
                @(negedge clk);
                start = 1'b0; gl++; guard++;
            end else begin
                m_valid = 1'b1; m_data = blk[511-32*i -: 32]; rdy = m_ready[0];
                @(negedge clk);
                if (rdy) i++;
                guard++;
            end
        end
        m_valid = 1'b0;
        chk("words_accepted", 256'(i), 256'd16);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!res_valid[0] && n < 300) begin @(negedge clk); n++; end
        chk("done_seen", 256'(res_valid[0]), 256'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc_blk, blk1, blk2;
        logic [255:0] mid;
        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        blk1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
        blk2 = {480'h0, 32'h000001c0};

        // pin the reference model with the published digests
        chk("model_abc", compress(IV, abc_blk), ABC_DIG);
        mid = compress(IV, blk1);
        chk("model_2blk", compress(mid, blk2), DIG2);

        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_busy[%0d]", k), 256'(busy[k]), 256'd0);
            chk($sformatf("rst_ready[%0d]", k), 256'(m_ready[k]), 256'd0);
            chk($sformatf("rst_rv[%0d]", k), 256'(res_valid[k]), 256'd0);
            chk($sformatf("rst_res[%0d]", k), res[k], 256'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // "abc", IV
        run_block(2'd0, '0, abc_blk, -1, 0);
        wait_done();
        for (int k = 0; k < 4; k++) chk($sformatf("abc_dig[%0d]", k), res[k], ABC_DIG);

        // two-block message, second block chained and started back-to-back
        @(negedge clk);
        run_block(2'd0, '0, blk1, -1, 0);
        wait_done();
        run_block(2'd1, '0, blk2, -1, 0);
        wait_done();
        for (int k = 0; k < 4; k++) chk($sformatf("chain_dig[%0d]", k), res[k], DIG2);

        // block 2 again from an external midstate
        @(negedge clk);
        run_block(2'd2, mid, blk2, -1, 0);
        wait_done();
        for (int k = 0; k < 4; k++) chk($sformatf("mid_dig[%0d]", k), res[k], DIG2);

        // five idle cycles after word 3, stray STARTs with MODE 1 during the gap
        @(negedge clk);
        run_block(2'd0, '0, abc_blk, 4, 5);
        wait_done();
        for (int k = 0; k < 4; k++) chk($sformatf("gap_dig[%0d]", k), res[k], ABC_DIG);

        // reset in the middle of the rounds (t=30 on the UNROLL=1 instance)
        @(negedge clk);
        run_block(2'd0, '0, abc_blk, -1, 0);
        while (cyc < t_start + 47) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("abort_busy[%0d]", k), 256'(busy[k]), 256'd0);
            chk($sformatf("abort_ready[%0d]", k), 256'(m_ready[k]), 256'd0);
            chk($sformatf("abort_rv[%0d]", k), 256'(res_valid[k]), 256'd0);
            chk($sformatf("abort_res[%0d]", k), res[k], 256'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(2'd1, '0, abc_blk, -1, 0);
        wait_done();
        for (int k = 0; k < 4; k++) chk($sformatf("post_rst_dig[%0d]", k), res[k], ABC_DIG);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
